execute_cycle: RTL and testbench

Execute stage of the 5-stage RV32I pipeline, between the decode-stage ID/EX register and the memory stage.
- Selects forwarded operands and performs the ALU operation.
- Resolves branches and jumps, and computes the redirect target.
- Holds the EX/MEM pipeline register whose outputs drive the memory stage's *M inputs directly.
- Its registered ALU_ResultM is also the EX/MEM forwarding source.

---
 rtl/execute_cycle_pkg.sv | 52 +++++
 rtl/execute_cycle_if.sv | 35 +++
 rtl/execute_cycle_alu.sv | 33 +++
 rtl/execute_cycle.sv | 105 ++++++++++
 tb/tb_execute_cycle.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, operand/forward selects,
// branch funct3 codes and the forward-mux helper.
package rv32_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } srca_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  // Select 11 falls back to the register-file value.
  function automatic logic [31:0] fwd_select(input logic [1:0] sel, input logic [31:0] rf,
                                             input logic [31:0] wb, input logic [31:0] mem);
    logic [31:0] val;
    case (sel)
      FWD_WB:  val = wb;
      FWD_MEM: val = mem;
      default: val = rf;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, bundled as one bus.
interface execute_cycle_if;
  logic        RegWriteE, LoadE, StoreE;
  logic [1:0]  ResultSrcE;
  logic        BranchE, JumpE, JalrE;
  logic [1:0]  ALUSrcAE;
  logic        ALUSrcBE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [31:0] InstrE, ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, LoadM, StoreM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, InstrM;

  modport master (
    output RegWriteE, LoadE, StoreE, ResultSrcE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE,
           ALUControlE, ForwardAE, ForwardBE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           InstrE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, LoadM, StoreM, ResultSrcM, RD_M, PCPlus4M,
           WriteDataM, ALU_ResultM, InstrM
  );

  modport slave (
    input  RegWriteE, LoadE, StoreE, ResultSrcE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE,
           ALUControlE, ForwardAE, ForwardBE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           InstrE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, LoadM, StoreM, ResultSrcM, RD_M, PCPlus4M,
           WriteDataM, ALU_ResultM, InstrM
  );
endinterface

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU; unused op codes yield zero.
module alu
  import rv32_exec_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  ALUControl,
  output logic [31:0] Result
);

  logic [4:0] shamt_s;
  assign shamt_s = SrcB[4:0];

  // Operation decode.
  always_comb begin
    Result = 32'd0;
    case (ALUControl)
      ALU_ADD:   Result = SrcA + SrcB;
      ALU_SUB:   Result = SrcA - SrcB;
      ALU_AND:   Result = SrcA & SrcB;
      ALU_OR:    Result = SrcA | SrcB;
      ALU_XOR:   Result = SrcA ^ SrcB;
      ALU_SLL:   Result = SrcA << shamt_s;
      ALU_SRL:   Result = SrcA >> shamt_s;
      ALU_SRA:   Result = $unsigned($signed(SrcA) >>> shamt_s);
      ALU_SLT:   Result = {31'd0, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU:  Result = {31'd0, (SrcA < SrcB)};
      ALU_PASSB: Result = SrcB;
      default:   Result = 32'd0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module execute_cycle
  import rv32_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  execute_cycle_if.slave ex
);

  logic [XLEN-1:0] rs1_fwd_s, rs2_fwd_s, src_a_s, src_b_s, alu_result_s, target_s;
  logic            branch_cond_s;

  logic            reg_write_r, load_r, store_r;
  logic [1:0]      result_src_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] pc_plus4_r, write_data_r, alu_result_r, instr_r;

  // EX/MEM forwarding reads the pre-edge register value.
  assign rs1_fwd_s = fwd_select(ex.ForwardAE, ex.RD1_E, ex.ResultW, alu_result_r);
  assign rs2_fwd_s = fwd_select(ex.ForwardBE, ex.RD2_E, ex.ResultW, alu_result_r);

  // Operand A select.
  always_comb begin
    src_a_s = 32'd0;
    case (ex.ALUSrcAE)
      SRCA_RS1: src_a_s = rs1_fwd_s;
      SRCA_PC:  src_a_s = ex.PCE;
      default:  src_a_s = 32'd0;
    endcase
  end

  assign src_b_s = ex.ALUSrcBE ? ex.Imm_Ext_E : rs2_fwd_s;

  alu u_alu (
    .SrcA       (src_a_s),
    .SrcB       (src_b_s),
    .ALUControl (ex.ALUControlE),
    .Result     (alu_result_s)
  );

  // Branch condition always compares the forwarded register operands.
  always_comb begin
    branch_cond_s = 1'b0;
    case (ex.InstrE[14:12])
      F3_BEQ:  branch_cond_s = (rs1_fwd_s == rs2_fwd_s);
      F3_BNE:  branch_cond_s = (rs1_fwd_s != rs2_fwd_s);
      F3_BLT:  branch_cond_s = ($signed(rs1_fwd_s) < $signed(rs2_fwd_s));
      F3_BGE:  branch_cond_s = ($signed(rs1_fwd_s) >= $signed(rs2_fwd_s));
      F3_BLTU: branch_cond_s = (rs1_fwd_s < rs2_fwd_s);
      F3_BGEU: branch_cond_s = (rs1_fwd_s >= rs2_fwd_s);
      default: branch_cond_s = 1'b0;
    endcase
  end

  // Redirect target; JALR clears bit 0 of the sum.
  always_comb begin
    target_s = 32'd0;
    if (ex.JalrE) begin
      target_s = (rs1_fwd_s + ex.Imm_Ext_E) & 32'hFFFF_FFFE;
    end else begin
      target_s = ex.PCE + ex.Imm_Ext_E;
    end
  end

  assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & branch_cond_s);
  assign ex.PCTargetE = target_s;

  // EX/MEM pipeline register, captured every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_r  <= 1'b0;
      load_r       <= 1'b0;
      store_r      <= 1'b0;
      result_src_r <= 2'b00;
      rd_r         <= 5'd0;
      pc_plus4_r   <= 32'd0;
      write_data_r <= 32'd0;
      alu_result_r <= 32'd0;
      instr_r      <= 32'd0;
    end else begin
      reg_write_r  <= ex.RegWriteE;
      load_r       <= ex.LoadE;
      store_r      <= ex.StoreE;
      result_src_r <= ex.ResultSrcE;
      rd_r         <= ex.RD_E;
      pc_plus4_r   <= ex.PCPlus4E;
      write_data_r <= rs2_fwd_s;
      alu_result_r <= alu_result_s;
      instr_r      <= ex.InstrE;
    end
  end

  assign ex.RegWriteM   = reg_write_r;
  assign ex.LoadM       = load_r;
  assign ex.StoreM      = store_r;
  assign ex.ResultSrcM  = result_src_r;
  assign ex.RD_M        = rd_r;
  assign ex.PCPlus4M    = pc_plus4_r;
  assign ex.WriteDataM  = write_data_r;
  assign ex.ALU_ResultM = alu_result_r;
  assign ex.InstrM      = instr_r;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed, table-driven bench for execute_cycle with hand-written forwarding and reset sequences.
module tb_execute_cycle;
  import rv32_exec_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  srca;
    logic        srcb;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, pc, resw;
    logic [2:0]  f3;
    logic        br, jmp, jalr, rw;
    logic [31:0] e_alu;
    logic        e_pcsrc;
    logic [31:0] e_tgt, e_wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_cycle_if bus();
  execute_cycle #(.XLEN(32)) dut (.clk(clk), .rst(rst), .ex(bus));

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t seq[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] srca, input logic srcb,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [31:0] resw, input logic [2:0] f3,
                              input logic br, input logic jmp, input logic jalr, input logic rw,
                              input logic [31:0] e_alu, input logic e_pcsrc,
                              input logic [31:0] e_tgt, input logic [31:0] e_wd);
    vec_t v;
    v.op = op; v.srca = srca; v.srcb = srcb; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc; v.resw = resw; v.f3 = f3;
    v.br = br; v.jmp = jmp; v.jalr = jalr; v.rw = rw;
    v.e_alu = e_alu; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt; v.e_wd = e_wd;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(input vec_t v, input int idx);
    logic [4:0] rd;
    rd = idx[4:0];
    return {7'b0000000, 5'd2, 5'd1, v.f3, rd, 7'b1100011};
  endfunction

  function automatic logic [73:0] pt_exp(input vec_t v, input int idx);
    logic [4:0] rd;
    logic [3:0] lo;
    rd = idx[4:0];
    lo = idx[3:0];
    return {v.rw, lo[0], lo[1], lo[3:2], rd, v.pc + 32'd4, instr_of(v, idx)};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v, input int idx);
    logic [3:0] lo;
    lo = idx[3:0];
    bus.ALUControlE = v.op;   bus.ALUSrcAE  = v.srca;  bus.ALUSrcBE = v.srcb;
    bus.ForwardAE   = v.fa;   bus.ForwardBE = v.fb;
    bus.RD1_E       = v.rd1;  bus.RD2_E     = v.rd2;   bus.Imm_Ext_E = v.imm;
    bus.PCE         = v.pc;   bus.PCPlus4E  = v.pc + 32'd4;
    bus.ResultW     = v.resw; bus.BranchE   = v.br;    bus.JumpE = v.jmp;
    bus.JalrE       = v.jalr; bus.RegWriteE = v.rw;
    bus.LoadE       = lo[0];  bus.StoreE    = lo[1];   bus.ResultSrcE = lo[3:2];
    bus.RD_E        = idx[4:0];
    bus.InstrE      = instr_of(v, idx);
  endtask

  task automatic check_regs(input string tag, input vec_t v, input int idx);
    chk({tag, " ALU_ResultM"}, bus.ALU_ResultM, v.e_alu);
    chk({tag, " WriteDataM"}, bus.WriteDataM, v.e_wd);
    chk({tag, " passthru"}, {bus.RegWriteM, bus.LoadM, bus.StoreM, bus.ResultSrcM, bus.RD_M,
                             bus.PCPlus4M, bus.InstrM}, pt_exp(v, idx));
  endtask

  task automatic apply(input string tag, input vec_t v, input int idx);
    @(negedge clk);
    set_inputs(v, idx);
    #1;
    chk({tag, " PCSrcE"}, bus.PCSrcE, v.e_pcsrc);
    chk({tag, " PCTargetE"}, bus.PCTargetE, v.e_tgt);
    @(posedge clk);
    #1;
    check_regs(tag, v, idx);
  endtask

  function automatic logic [159:0] all_m();
    return {bus.RegWriteM, bus.LoadM, bus.StoreM, bus.ResultSrcM, bus.RD_M, bus.PCPlus4M,
            bus.WriteDataM, bus.ALU_ResultM, bus.InstrM};
  endfunction

  initial begin
    // op, srca, srcb, fa, fb, rd1, rd2, imm, pc, resw, f3, br, jmp, jalr, rw | alu, pcsrc, tgt, wd
    tbl.push_back(mk(ALU_ADD, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 1'b0, 32'h100, 32'd7));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd9, 32'd12, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h100, 32'd12));
    tbl.push_back(mk(ALU_AND, 2'b00, 1'b0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000, 1'b0, 32'h100, 32'hFF00));
    tbl.push_back(mk(ALU_OR, 2'b00, 1'b0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFF0, 1'b0, 32'h100, 32'hFF00));
    tbl.push_back(mk(ALU_XOR, 2'b00, 1'b0, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0FF0, 1'b0, 32'h100, 32'hFF00));
    tbl.push_back(mk(ALU_SLL, 2'b00, 1'b0, 2'b00, 2'b00, 32'd1, 32'd31, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h100, 32'd31));
    tbl.push_back(mk(ALU_SRL, 2'b00, 1'b0, 2'b00, 2'b00, 32'h8000_0000, 32'h24, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0800_0000, 1'b0, 32'h100, 32'h24));
    tbl.push_back(mk(ALU_SRA, 2'b00, 1'b0, 2'b00, 2'b00, 32'h8000_0000, 32'h24, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF800_0000, 1'b0, 32'h100, 32'h24));
    tbl.push_back(mk(ALU_SLT, 2'b00, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 32'h100, 32'd1));
    tbl.push_back(mk(ALU_SLTU, 2'b00, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h100, 32'd1));
    tbl.push_back(mk(ALU_PASSB, 2'b00, 1'b1, 2'b00, 2'b00, 32'd0, 32'h55, 32'h12345, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345, 1'b0, 32'h12445, 32'h55));
    tbl.push_back(mk(4'b1011, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h100, 32'd7));
    tbl.push_back(mk(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h100, 32'd7));
    tbl.push_back(mk(ALU_ADD, 2'b01, 1'b1, 2'b00, 2'b00, 32'hDEAD, 32'd0, 32'h10, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 1'b0, 32'h110, 32'd0));
    tbl.push_back(mk(ALU_ADD, 2'b10, 1'b1, 2'b00, 2'b00, 32'h1234, 32'd0, 32'hABCD_E000, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hABCD_E000, 1'b0, 32'hABCD_E100, 32'd0));
    tbl.push_back(mk(ALU_ADD, 2'b11, 1'b0, 2'b00, 2'b00, 32'h1234, 32'd7, 32'd0, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 32'h100, 32'd7));
    tbl.push_back(mk(ALU_ADD, 2'b00, 1'b0, 2'b01, 2'b01, 32'd1, 32'd2, 32'd0, 32'h100, 32'd40, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd80, 1'b0, 32'h100, 32'd40));
    tbl.push_back(mk(ALU_ADD, 2'b00, 1'b0, 2'b11, 2'b11, 32'd3, 32'd4, 32'd0, 32'h100, 32'd100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 32'h100, 32'd4));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'd0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 32'hF8, 32'd1));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'd0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'hF8, 32'd1));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd5, 32'h40, 32'h100, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h140, 32'd5));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd5, 32'h40, 32'h100, 32'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h140, 32'd5));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h100, 32'd0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1, 32'h140, 32'hFFFF_FFFF));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h100, 32'd0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0, 32'h140, 32'hFFFF_FFFF));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd5, 32'h40, 32'h100, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h140, 32'd5));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b00, 32'd5, 32'd5, 32'h40, 32'h100, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h140, 32'd5));
    tbl.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b00, 2'b01, 32'd9, 32'd5, 32'h40, 32'h100, 32'd9, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h140, 32'd9));
    tbl.push_back(mk(ALU_ADD, 2'b00, 1'b1, 2'b00, 2'b00, 32'h1001, 32'd0, 32'd2, 32'h100, 32'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1003, 1'b1, 32'h1002, 32'd0));
    tbl.push_back(mk(ALU_ADD, 2'b01, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 32'h20, 32'h100, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h120, 1'b1, 32'h120, 32'd0));
    tbl.push_back(mk(ALU_ADD, 2'b01, 1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'd0));
    tbl.push_back(mk(ALU_ADD, 2'b00, 1'b1, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'h100, 32'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 1'b1, 32'd0, 32'd0));

    // Order-dependent sequence: each step may forward the previous ALU_ResultM.
    seq.push_back(mk(ALU_ADD, 2'b00, 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'h200, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 32'h200, 32'd4));
    seq.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b10, 2'b00, 32'd99, 32'd2, 32'd0, 32'h204, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 32'h204, 32'd2));
    seq.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b01, 2'b00, 32'd99, 32'd2, 32'd0, 32'h208, 32'd20, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd18, 1'b0, 32'h208, 32'd2));
    seq.push_back(mk(ALU_ADD, 2'b00, 1'b1, 2'b00, 2'b10, 32'h200, 32'd0, 32'd4, 32'h20C, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0, 32'h210, 32'd18));
    seq.push_back(mk(ALU_SUB, 2'b00, 1'b0, 2'b10, 2'b00, 32'd0, 32'h204, 32'h40, 32'h210, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h250, 32'h204));
    seq.push_back(mk(ALU_ADD, 2'b00, 1'b1, 2'b10, 2'b00, 32'h7777, 32'd0, 32'd3, 32'h214, 32'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 32'd2, 32'd0));

    set_inputs(tbl[0], 0);
    #1;
    chk("reset state", all_m(), 160'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i], i);
    end
    for (int i = 0; i < seq.size(); i++) begin
      apply($sformatf("seq%0d", i), seq[i], i + 40);
    end

    // Asynchronous reset mid-cycle with the pipeline loaded.
    apply("preload", tbl[1], 7);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset", all_m(), 160'd0);
    set_inputs(tbl[0], 3);
    @(posedge clk);
    #1;
    chk("reset held over edge", all_m(), 160'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset released no edge", all_m(), 160'd0);
    @(posedge clk);
    #1;
    check_regs("first capture", tbl[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
